// File: rtl/lfsr_crypt_sequencer.sv
// lfsr_crypt_sequencer: runs one LFSR encrypt/decrypt job over the shared DM.
// Job parameters (pre_length, taps, seed) are read from DM[PRM_BASE..+2].
// Encrypt pads the message into a FRAME_LEN-byte ciphertext frame at CT_BASE.
// Decrypt recovers the message from that frame.
module lfsr_crypt_sequencer #(
   parameter int          MSG_LEN   = 41,
   parameter int          FRAME_LEN = 64,
   parameter int          PRM_BASE  = 41,
   parameter int          CT_BASE   = 64,
   parameter logic [7:0]  PAD_CHAR  = 8'h20,
   parameter int          AW        = 8
) (
   input  logic          clk,
   input  logic          init_n,
   input  logic          start,
   input  logic          mode,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   // S_DADV is the decrypt key pre-advance phase (one LFSR step per cycle).
   typedef enum logic [3:0] {
      S_IDLE, S_P0, S_P1, S_P2, S_P3, S_ENC, S_DADV, S_DEC, S_FIN
   } state_t;

   localparam logic [7:0]    PRE_MAX  = 8'(FRAME_LEN - MSG_LEN);
   localparam logic [7:0]    MSG_L    = 8'(MSG_LEN);
   localparam logic [7:0]    LAST_FR  = 8'(FRAME_LEN - 1);
   localparam logic [7:0]    LAST_MSG = 8'(MSG_LEN - 1);
   localparam logic [AW-1:0] A_PRM    = AW'(PRM_BASE);
   localparam logic [AW-1:0] A_CT     = AW'(CT_BASE);

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;      // frame index (enc), message index or advance count (dec)
   logic          ph_q, ph_d;        // 0 = read cycle A, 1 = write cycle B of a message byte
   logic [7:0]    pre_q, pre_d;      // clamped preamble length
   logic [7:0]    taps_q, taps_d;
   logic [7:0]    lfsr_q, lfsr_d;    // key for the byte currently being processed
   logic          mode_q, mode_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wr_q, wr_d;
   logic          rsrc_q, rsrc_d;    // write source: 1 = DM read data, 0 = pad character
   logic          cur_pad, nxt_pad;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
      return {s[6:0], ^(s & t)};
   endfunction

   // Next-state sequencing, then the registered DM outputs for the cycle being entered.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ph_d    = ph_q;
      pre_d   = pre_q;
      taps_d  = taps_q;
      lfsr_d  = lfsr_q;
      mode_d  = mode_q;
      done_d  = done_q;
      cur_pad = (idx_q < pre_q) || (idx_q >= pre_q + MSG_L);

      case (state_q)
         S_IDLE, S_FIN: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_P0;
               mode_d  = mode;
               done_d  = 1'b0;
            end
         end
         S_P0: state_d = S_P1;
         S_P1: begin
            pre_d   = (mem_rdata > PRE_MAX) ? PRE_MAX : mem_rdata;
            state_d = S_P2;
         end
         S_P2: begin
            taps_d  = mem_rdata;
            state_d = S_P3;
         end
         S_P3: begin
            lfsr_d = mem_rdata;
            idx_d  = '0;
            ph_d   = 1'b0;
            if (!mode_q)          state_d = S_ENC;
            else if (pre_q == '0) state_d = S_DEC;
            else                  state_d = S_DADV;
         end
         S_ENC: begin
            if (cur_pad || ph_q) begin
               lfsr_d = lfsr_step(lfsr_q, taps_q);
               ph_d   = 1'b0;
               if (idx_q == LAST_FR) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               ph_d = 1'b1;
            end
         end
         S_DADV: begin
            // Frame byte 0 is always padding here, so DM[CT_BASE]^PAD recovers key0.
            lfsr_d = lfsr_step((idx_q == '0) ? (mem_rdata ^ PAD_CHAR) : lfsr_q, taps_q);
            if (idx_q + 8'd1 == pre_q) begin
               idx_d   = '0;
               state_d = S_DEC;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         S_DEC: begin
            if (ph_q) begin
               lfsr_d = lfsr_step(lfsr_q, taps_q);
               ph_d   = 1'b0;
               if (idx_q == LAST_MSG) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               ph_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      addr_d  = addr_q;
      wr_d    = 1'b0;
      rsrc_d  = 1'b0;
      nxt_pad = (idx_d < pre_d) || (idx_d >= pre_d + MSG_L);
      case (state_d)
         S_P0: addr_d = A_PRM;
         S_P1: addr_d = A_PRM + AW'(1);
         S_P2: addr_d = A_PRM + AW'(2);
         S_P3: if (mode_d) addr_d = A_CT;
         S_ENC: begin
            if (nxt_pad) begin
               addr_d = A_CT + AW'(idx_d);
               wr_d   = 1'b1;
            end else if (ph_d) begin
               addr_d = A_CT + AW'(idx_d);
               wr_d   = 1'b1;
               rsrc_d = 1'b1;
            end else begin
               addr_d = AW'(idx_d - pre_d);
            end
         end
         S_DEC: begin
            if (ph_d) begin
               addr_d = AW'(idx_d);
               wr_d   = 1'b1;
               rsrc_d = 1'b1;
            end else begin
               addr_d = A_CT + AW'(pre_d + idx_d);
            end
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
   end

   // Single state register for the FSM, datapath and registered outputs.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ph_q    <= 1'b0;
         pre_q   <= '0;
         taps_q  <= '0;
         lfsr_q  <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         rsrc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ph_q    <= ph_d;
         pre_q   <= pre_d;
         taps_q  <= taps_d;
         lfsr_q  <= lfsr_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         rsrc_q  <= rsrc_d;
      end
   end

   // Write data is formed in the write cycle itself: the sync RAM only returns
   // the message byte during that cycle, so only the source select is registered.
   assign mem_wdata = wr_q ? ((rsrc_q ? mem_rdata : PAD_CHAR) ^ lfsr_q) : 8'h00;
   assign mem_addr  = addr_q;
   assign mem_wr_en = wr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_lfsr_crypt_sequencer.sv
// Bench for lfsr_crypt_sequencer: sync-RAM model, reference cipher model,
// directed corner jobs plus randomized encrypt/decrypt round trips.
module tb_lfsr_crypt_sequencer;

   logic       clk = 1'b0;
   logic       init_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       busy, done, mem_wr_en;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   lfsr_crypt_sequencer dut (
      .clk       (clk),
      .init_n    (init_n),
      .start     (start),
      .mode      (mode),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   logic [7:0] mem [0:255];
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
   int         wcnt = 0, wlow = 0;

   // Sync RAM: the bench loader has its own port-like path, DUT writes are counted.
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_wr_en) begin
         mem[mem_addr] <= mem_wdata;
         wcnt <= wcnt + 1;
         if (mem_addr < 8'd64) wlow <= wlow + 1;
      end
      mem_rdata <= mem[mem_addr];
   end

   int         n_chk = 0, n_pass = 0;
   logic [7:0] msg    [0:40];
   logic [7:0] exp_fr [0:63];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic ld_byte(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   function automatic int pre_eff(input logic [7:0] pre);
      return (pre > 8'd23) ? 23 : int'(pre);
   endfunction

   // Reference cipher: pad message into a 64-byte frame, XOR with successive LFSR keys.
   task automatic model_enc(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
      int pe;
      logic [7:0] k, src;
      pe = pre_eff(pre);
      k  = seed;
      for (int i = 0; i < 64; i++) begin
         src = (i < pe || i >= pe + 41) ? 8'h20 : msg[i - pe];
         exp_fr[i] = src ^ k;
         k = {k[6:0], ^(k & taps)};
      end
   endtask

   task automatic setup(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
      for (int i = 0; i < 41; i++) begin
         msg[i] = 8'($urandom_range(33, 126));
         ld_byte(8'(i), msg[i]);
      end
      ld_byte(8'd41, pre);
      ld_byte(8'd42, taps);
      ld_byte(8'd43, seed);
      model_enc(pre, taps, seed);
   endtask

   // Pulse start and count busy cycles; optionally poke start or reset mid-job.
   task automatic run_job(input logic m, input int mid_start_at, input int abort_at,
                          output int cyc, output int done_early, output logic ab);
      @(negedge clk);
      start = 1'b1; mode = m;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; done_early = 0; ab = 1'b0;
      while (busy && cyc < 400) begin
         if (done) done_early++;
         cyc++;
         if (cyc == mid_start_at) begin start = 1'b1; mode = ~m; end
         else start = 1'b0;
         if (cyc == abort_at) begin
            init_n = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
            ab = 1'b1;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("job_no_timeout", 32'(cyc < 400), 32'd1);
      if (ab) begin
         @(negedge clk);
         @(negedge clk);
         init_n = 1'b1;
         @(negedge clk);
         chk("post_abort_idle", 32'(busy), 32'd0);
      end
   endtask

   task automatic enc_dec(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed,
                          input bit do_dec, input int mid_start_at);
      int cyc, de, w0, l0, pe;
      logic ab;
      setup(pre, taps, seed);
      w0 = wcnt; l0 = wlow;
      run_job(1'b0, mid_start_at, 0, cyc, de, ab);
      chk("enc_cycles", 32'(cyc), 32'd109);
      chk("enc_done", 32'(done), 32'd1);
      chk("enc_done_during_busy", 32'(de), 32'd0);
      chk("enc_writes", 32'(wcnt - w0), 32'd64);
      chk("enc_low_writes", 32'(wlow - l0), 32'd0);
      for (int i = 0; i < 64; i++)
         chk($sformatf("enc_dm[%0d]", 64 + i), 32'(mem[64 + i]), 32'(exp_fr[i]));
      repeat (2) @(negedge clk);
      chk("done_sticky", 32'(done), 32'd1);
      if (do_dec) begin
         pe = pre_eff(pre);
         for (int j = 0; j < 41; j++) ld_byte(8'(j), 8'h00);
         // Corrupt the stored seed: decrypt must take key0 from the frame when pre_eff >= 1.
         if (pe != 0) ld_byte(8'd43, seed ^ 8'h5a);
         w0 = wcnt;
         run_job(1'b1, 0, 0, cyc, de, ab);
         chk("dec_cycles", 32'(cyc), 32'(4 + pe + 82));
         chk("dec_done", 32'(done), 32'd1);
         chk("dec_writes", 32'(wcnt - w0), 32'd41);
         for (int j = 0; j < 41; j++)
            chk($sformatf("dec_dm[%0d]", j), 32'(mem[j]), 32'(msg[j]));
      end
   endtask

   initial begin
      int cyc, de;
      logic ab;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      init_n = 1'b1;
      @(negedge clk);

      // Known-answer job: first two frame bytes are fixed by the seed and taps.
      enc_dec(8'd9, 8'he1, 8'h41, 1'b1, 0);
      chk("kat_dm64", 32'(mem[64]), 32'h61);
      chk("kat_dm65", 32'(mem[65]), 32'ha2);

      // Zero seed: frame is the padded plaintext.
      enc_dec(8'd9, 8'hb8, 8'h00, 1'b0, 0);
      chk("seed0_pad0", 32'(mem[64]), 32'h20);
      chk("seed0_msg0", 32'(mem[73]), 32'(msg[0]));
      chk("seed0_tail", 32'(mem[127]), 32'h20);

      enc_dec(8'd30, 8'h8e, 8'h5c, 1'b1, 0);   // clamped preamble
      enc_dec(8'd23, 8'h71, 8'hc3, 1'b1, 0);   // largest legal preamble
      enc_dec(8'd0,  8'hd4, 8'h37, 1'b1, 0);   // no preamble: decrypt uses stored seed
      enc_dec(8'd1,  8'h2d, 8'hff, 1'b1, 0);

      // Start pulse in the middle of a job is ignored.
      enc_dec(8'd9, 8'he1, 8'h41, 1'b0, 50);

      // Reset mid-job, then a fresh full job.
      setup(8'd5, 8'hb8, 8'h9c);
      run_job(1'b0, 0, 40, cyc, de, ab);
      chk("abort_taken", 32'(ab), 32'd1);
      enc_dec(8'd12, 8'h96, 8'h3b, 1'b1, 0);

      for (int r = 0; r < 6; r++)
         enc_dec(8'($urandom_range(0, 30)), 8'($urandom), 8'($urandom), 1'b1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
